// File: rtl/bcd_chain_pkg.sv
// -----------------------------------------------------------------------------
// bcd_chain_pkg
// Shared types and constants for the BCD decade chain and its serialiser.
//   bcd_t       : one packed BCD digit (4 bits)
//   BCD_MAX     : largest legal BCD digit value (9)
//   ser_state_t : serialiser FSM states (IDLE, SEND)
// -----------------------------------------------------------------------------
package bcd_chain_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/bcd_digit_chain_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Single decade cell of the BCD chain. Counts 0..9 and wraps to 0.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-high (value -> 0)
//   clr       : synchronous clear (value -> 0), wins over en
//   en        : chain-wide increment enable
//   carry_in  : all lower digits are 9 (tie high for digit 0)
//   value     : current BCD digit
//   carry_out : carry_in & (value == 9); feeds the next digit's carry_in
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_chain_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic carry_in,
    output bcd_t value,
    output logic carry_out
);

    // NOTE: sequential state is assigned with <= so every cell samples the
    // pre-edge values of its neighbours; blocking assignments here would make
    // the result depend on process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en && carry_in) begin
            value <= (value == BCD_MAX) ? bcd_t'(0) : value + 4'd1;
        end
    end

    assign carry_out = carry_in & (value == BCD_MAX);

endmodule

// File: rtl/bcd_digit_chain.sv
// -----------------------------------------------------------------------------
// bcd_digit_chain
// Multi-digit decimal counter driven by an upstream carry, with a sticky
// overflow flag and a snapshot-and-serialise readout (MSD first, valid/ready).
// Build option: define BCD_CHAIN_SATURATE_EN to hold the digits at all-9 on
// overflow instead of wrapping to all-0.
// Parameters:
//   DIGITS    : number of BCD digits (1..8)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   cin       : count enable (one increment per sampled-high cycle)
//   clr       : synchronous clear of digits and ovf (highest priority)
//   hold      : freeze counting, cin ignored
//   digits    : BCD value, digit i at [4i+3:4i]
//   ovf       : sticky overflow flag
//   snap_req  : request snapshot + serial readout (ignored while busy)
//   busy      : serialiser active
//   ser_valid, ser_ready, ser_digit, ser_last : serial digit handshake
// -----------------------------------------------------------------------------
module bcd_digit_chain
    import bcd_chain_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cin,
    input  logic                  clr,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  ovf,
    input  logic                  snap_req,
    output logic                  busy,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output bcd_t                  ser_digit,
    output logic                  ser_last
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ---------------------------------------------------------------- counter
    logic                inc;
    logic                all_nine;
    logic                cell_en;
    logic [DIGITS:0]     carry;
    bcd_t [DIGITS-1:0]   value;

    assign inc      = cin & ~hold & ~clr;
    assign carry[0] = 1'b1;
    // The carry out of the top cell is exactly "every digit is 9".
    assign all_nine = carry[DIGITS];

`ifdef BCD_CHAIN_SATURATE_EN
    // Suppress the increment once full so the chain stays parked at all-9.
    assign cell_en = inc & ~all_nine;
`else
    assign cell_en = inc;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .en        (cell_en),
            .carry_in  (carry[i]),
            .value     (value[i]),
            .carry_out (carry[i+1])
        );
    end

    assign digits = value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (inc && all_nine) begin
            ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------- serialiser
    ser_state_t          state;
    ser_state_t          state_next;
    bcd_t [DIGITS-1:0]   snapshot;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven from always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (snap_req) state_next = SEND;
            SEND:    if (ser_ready && idx == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot captures the pre-edge digits, so a same-cycle clr or inc
    // does not leak into the stream.
    // NOTE: the snapshot bank is reset along with the rest of the state; it is
    // small, and it keeps ser_digit free of X after reset in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
            idx      <= '0;
        end else if (state == IDLE && snap_req) begin
            snapshot <= value;
            idx      <= IDX_W'(DIGITS - 1);
        end else if (state == SEND && ser_ready && idx != '0) begin
            idx      <= idx - 1'b1;
        end
    end

    always_comb begin
        busy      = 1'b0;
        ser_valid = 1'b0;
        ser_digit = '0;
        ser_last  = 1'b0;
        if (state == SEND) begin
            busy      = 1'b1;
            ser_valid = 1'b1;
            ser_digit = snapshot[idx];
            ser_last  = (idx == '0);
        end
    end

endmodule

// File: tb/tb_bcd_digit_chain.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_chain
// Self-checking bench for bcd_digit_chain (DIGITS=3). The reference model keeps
// the count as a plain integer, converts it to BCD by division, and models the
// serial stream as a queue of digits pending delivery.
// Honours BCD_CHAIN_SATURATE_EN in the model when the macro is defined.
// -----------------------------------------------------------------------------
module tb_bcd_digit_chain;

    localparam int DIGITS = 3;
    localparam int MAXV   = 999;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cin = 1'b0;
    logic                clr = 1'b0;
    logic                hold = 1'b0;
    logic [4*DIGITS-1:0] digits;
    logic                ovf;
    logic                snap_req = 1'b0;
    logic                busy;
    logic                ser_valid;
    logic                ser_ready = 1'b0;
    logic [3:0]          ser_digit;
    logic                ser_last;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    logic [3:0] m_q[$];

    bcd_digit_chain #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cin       (cin),
        .clr       (clr),
        .hold      (hold),
        .digits    (digits),
        .ovf       (ovf),
        .snap_req  (snap_req),
        .busy      (busy),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_digit (ser_digit),
        .ser_last  (ser_last)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] bcd_of(int v);
        logic [4*DIGITS-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic exp_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic exp_last();
        return m_q.size() == 1;
    endfunction

    function automatic logic [3:0] exp_digit();
        return (m_q.size() > 0) ? m_q[0] : 4'd0;
    endfunction

    // Advance one clock: capture the inputs the DUT will sample, update the
    // model, and return 1 ns after the edge.
    task automatic tick();
        logic c_cin   = cin;
        logic c_hold  = hold;
        logic c_clr   = clr;
        logic c_snap  = snap_req;
        logic c_ready = ser_ready;
        int   pre     = m_cnt;
        @(posedge clk);
        if (m_q.size() > 0) begin
            if (c_ready) void'(m_q.pop_front());
        end else if (c_snap) begin
            for (int i = DIGITS - 1; i >= 0; i--)
                m_q.push_back(4'((pre / (10 ** i)) % 10));
        end
        if (c_clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (c_cin && !c_hold) begin
            if (m_cnt == MAXV) begin
                m_ovf = 1'b1;
`ifdef BCD_CHAIN_SATURATE_EN
                m_cnt = MAXV;
`else
                m_cnt = 0;
`endif
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic clear_chain();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (digits !== '0)   begin miscompares++; $display("FAIL reset digits: got %h expected 000", digits); end
        vectors++; if (ovf !== 1'b0)    begin miscompares++; $display("FAIL reset ovf: got %b expected 0", ovf); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        vectors++; if (ser_valid !== 1'b0) begin miscompares++; $display("FAIL reset ser_valid: got %b expected 0", ser_valid); end
        vectors++; if (ser_digit !== 4'd0) begin miscompares++; $display("FAIL reset ser_digit: got %h expected 0", ser_digit); end
        vectors++; if (ser_last !== 1'b0)  begin miscompares++; $display("FAIL reset ser_last: got %b expected 0", ser_last); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_count_pulses();
        for (int n = 0; n < 25; n++) begin
            cin = 1'b1;
            tick();
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL pulse digits: got %h expected %h", digits, bcd_of(m_cnt)); end
            cin = 1'b0;
            tick();
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL pulse idle digits: got %h expected %h", digits, bcd_of(m_cnt)); end
        end
        vectors++; if (digits !== 12'h025) begin miscompares++; $display("FAIL pulse final: got %h expected 025", digits); end
        vectors++; if (ovf !== 1'b0)       begin miscompares++; $display("FAIL pulse ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [11:0] wrap_val;
`ifdef BCD_CHAIN_SATURATE_EN
        wrap_val = 12'h999;
`else
        wrap_val = 12'h000;
`endif
        clear_chain();
        cin = 1'b1;
        for (int n = 0; n < MAXV; n++) begin
            tick();
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL preload digits: got %h expected %h", digits, bcd_of(m_cnt)); end
        end
        vectors++; if (digits !== 12'h999) begin miscompares++; $display("FAIL preload final: got %h expected 999", digits); end
        vectors++; if (ovf !== 1'b0)       begin miscompares++; $display("FAIL preload ovf: got %b expected 0", ovf); end
        tick();
        vectors++; if (digits !== wrap_val) begin miscompares++; $display("FAIL overflow digits: got %h expected %h", digits, wrap_val); end
        vectors++; if (ovf !== 1'b1)        begin miscompares++; $display("FAIL overflow ovf: got %b expected 1", ovf); end
        for (int n = 0; n < 4; n++) begin
            cin = n[0];
            tick();
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL post-ovf digits: got %h expected %h", digits, bcd_of(m_cnt)); end
            vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf sticky: got %b expected 1", ovf); end
        end
        cin = 1'b0;
        clear_chain();
        vectors++; if (digits !== '0)   begin miscompares++; $display("FAIL clr digits: got %h expected 000", digits); end
        vectors++; if (ovf !== 1'b0)    begin miscompares++; $display("FAIL clr ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_hold();
        clear_chain();
        cin = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            hold = (c >= 3 && c <= 5);
            tick();
        end
        hold = 1'b0;
        vectors++; if (digits !== 12'h007) begin miscompares++; $display("FAIL hold digits: got %h expected 007", digits); end
        vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL hold model: got %h expected %h", digits, bcd_of(m_cnt)); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cin = 1'b0;
        vectors++; if (digits !== '0) begin miscompares++; $display("FAIL clr+cin digits: got %h expected 000", digits); end
    endtask

    task automatic load_472();
        clear_chain();
        cin = 1'b1;
        repeat (472) tick();
        cin = 1'b0;
    endtask

    // cin keeps counting while the snapshot streams out.
    task automatic test_stream();
        load_472();
        snap_req  = 1'b1;
        ser_ready = 1'b1;
        cin       = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            snap_req = 1'b0;
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL stream digits: got %h expected %h", digits, bcd_of(m_cnt)); end
            vectors++; if (busy !== exp_valid())      begin miscompares++; $display("FAIL stream busy: got %b expected %b", busy, exp_valid()); end
            vectors++; if (ser_valid !== exp_valid()) begin miscompares++; $display("FAIL stream valid: got %b expected %b", ser_valid, exp_valid()); end
            vectors++; if (ser_last !== exp_last())   begin miscompares++; $display("FAIL stream last: got %b expected %b", ser_last, exp_last()); end
            if (exp_valid()) begin
                vectors++; if (ser_digit !== exp_digit()) begin miscompares++; $display("FAIL stream digit: got %h expected %h", ser_digit, exp_digit()); end
            end
        end
        cin = 1'b0;
    endtask

    // Stall on the middle digit; a snap_req during the stall must be ignored.
    task automatic test_stall();
        load_472();
        snap_req  = 1'b1;
        ser_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            snap_req  = (c == 3);
            ser_ready = !(c >= 1 && c <= 4);
            vectors++; if (ser_valid !== exp_valid()) begin miscompares++; $display("FAIL stall valid: got %b expected %b", ser_valid, exp_valid()); end
            vectors++; if (ser_last !== exp_last())   begin miscompares++; $display("FAIL stall last: got %b expected %b", ser_last, exp_last()); end
            vectors++; if (busy !== exp_valid())      begin miscompares++; $display("FAIL stall busy: got %b expected %b", busy, exp_valid()); end
            if (exp_valid()) begin
                vectors++; if (ser_digit !== exp_digit()) begin miscompares++; $display("FAIL stall digit: got %h expected %h", ser_digit, exp_digit()); end
            end
        end
        snap_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_chain();
        cin       = 1'b1;
        repeat (58) tick();
        cin       = 1'b0;
        snap_req  = 1'b1;
        ser_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cin = c[1];
            tick();
            vectors++; if (ser_valid !== exp_valid()) begin miscompares++; $display("FAIL b2b valid: got %b expected %b", ser_valid, exp_valid()); end
            vectors++; if (ser_last !== exp_last())   begin miscompares++; $display("FAIL b2b last: got %b expected %b", ser_last, exp_last()); end
            if (exp_valid()) begin
                vectors++; if (ser_digit !== exp_digit()) begin miscompares++; $display("FAIL b2b digit: got %h expected %h", ser_digit, exp_digit()); end
            end
        end
        snap_req = 1'b0;
        cin      = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cin       = $urandom_range(0, 1);
            hold      = ($urandom_range(0, 3) == 0);
            clr       = ($urandom_range(0, 40) == 0);
            snap_req  = ($urandom_range(0, 3) == 0);
            ser_ready = ($urandom_range(0, 3) != 0);
            tick();
            vectors++; if (digits !== bcd_of(m_cnt)) begin miscompares++; $display("FAIL rand digits: got %h expected %h", digits, bcd_of(m_cnt)); end
            vectors++; if (ovf !== m_ovf)             begin miscompares++; $display("FAIL rand ovf: got %b expected %b", ovf, m_ovf); end
            vectors++; if (ser_valid !== exp_valid()) begin miscompares++; $display("FAIL rand valid: got %b expected %b", ser_valid, exp_valid()); end
            vectors++; if (ser_last !== exp_last())   begin miscompares++; $display("FAIL rand last: got %b expected %b", ser_last, exp_last()); end
            if (exp_valid()) begin
                vectors++; if (ser_digit !== exp_digit()) begin miscompares++; $display("FAIL rand digit: got %h expected %h", ser_digit, exp_digit()); end
            end
        end
        cin = 1'b0; hold = 1'b0; clr = 1'b0; snap_req = 1'b0; ser_ready = 1'b1;
        repeat (DIGITS + 2) tick();
    endtask

    // Reset is applied between clock edges and checked before the next edge.
    task automatic test_async_reset();
        load_472();
        snap_req  = 1'b1;
        ser_ready = 1'b1;
        tick();
        snap_req  = 1'b0;
        tick();
        vectors++; if (ser_valid !== 1'b1) begin miscompares++; $display("FAIL pre-reset valid: got %b expected 1", ser_valid); end
        #1 rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (ser_valid !== 1'b0) begin miscompares++; $display("FAIL async valid: got %b expected 0", ser_valid); end
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL async busy: got %b expected 0", busy); end
        vectors++; if (digits !== '0)      begin miscompares++; $display("FAIL async digits: got %h expected 000", digits); end
        vectors++; if (ser_last !== 1'b0)  begin miscompares++; $display("FAIL async last: got %b expected 0", ser_last); end
        @(negedge clk) rst = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post-reset busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_count_pulses();
        test_overflow();
        test_hold();
        test_stream();
        test_stall();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
